// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: aluop
// encodings (matching ID control), FSM state encoding and decode helpers.
package hilo_muldiv_ctrl_pkg;

    localparam logic [4:0] OP_MULT  = 5'b01100;
    localparam logic [4:0] OP_MULTU = 5'b01101;
    localparam logic [4:0] OP_DIV   = 5'b01110;
    localparam logic [4:0] OP_DIVU  = 5'b01111;
    localparam logic [4:0] OP_MFHI  = 5'b01000;
    localparam logic [4:0] OP_MTHI  = 5'b01001;
    localparam logic [4:0] OP_MFLO  = 5'b01010;
    localparam logic [4:0] OP_MTLO  = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // True for any of the eight codes that touch HI/LO.
    function automatic logic is_hilo_op(input logic [4:0] op);
        logic hit;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    // True for the four multi-cycle arithmetic codes.
    function automatic logic is_muldiv_op(input logic [4:0] op);
        logic hit;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_iter.sv
// Radix-2 iteration datapath. Operands are unsigned magnitudes; the
// controller handles signs. The 2W-bit accumulator holds {partial product
// high, multiplier} for multiply and {remainder, dividend/quotient} for
// divide, so after W steps it reads {HI, LO} directly.
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    output logic [2*W-1:0]   result
);

    logic [2*W-1:0] acc_r;
    logic [W-1:0]   b_r;
    logic [2*W-1:0] acc_nxt_s;
    logic [W:0]     mul_sum_s;
    logic [W:0]     div_trial_s;
    logic [W:0]     div_diff_s;

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, b_r} : {(W+1){1'b0}});
        div_trial_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_diff_s  = div_trial_s - {1'b0, b_r};
        if (is_div) begin
            if (div_diff_s[W] == 1'b0) begin
                acc_nxt_s = {div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
            end else begin
                acc_nxt_s = {div_trial_s[W-1:0], acc_r[W-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = {mul_sum_s, acc_r[W-1:1]};
        end
    end

    // Accumulator and divisor/multiplicand registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r <= {(2*W){1'b0}};
            b_r   <= {W{1'b0}};
        end else if (load) begin
            acc_r <= {{W{1'b0}}, op_a};
            b_r   <= op_b;
        end else if (step) begin
            acc_r <= acc_nxt_s;
        end
    end

    assign result = acc_r;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multi-cycle MULT/DIV sequencer sitting beside the ALU in
// EX. Ops retire immediately; only a later HI/LO op seen while busy stalls.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int ITER = 32,
    parameter int W    = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         op_valid,
    input  logic [4:0]   aluop,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         flush,
    output logic         stall,
    output logic [W-1:0] hilo_rdata,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(ITER);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic             is_div_r;
    logic             res_neg_r;
    logic             rem_neg_r;
    logic             dz_r;
    logic [W-1:0]     raw_a_r;
    logic [W-1:0]     hi_r;
    logic [W-1:0]     lo_r;

    logic             hiloop_s;
    logic             muldiv_s;
    logic             signed_op_s;
    logic             div_op_s;
    logic [W-1:0]     mag_a_s;
    logic [W-1:0]     mag_b_s;
    logic             accept_s;
    logic             step_s;
    logic             hi_we_s;
    logic             lo_we_s;
    logic [W-1:0]     hi_nxt_s;
    logic [W-1:0]     lo_nxt_s;
    logic [2*W-1:0]   raw_res_s;
    logic [2*W-1:0]   prod_fix_s;
    logic [W-1:0]     quo_fix_s;
    logic [W-1:0]     rem_fix_s;

    // Decode the incoming op and form operand magnitudes for signed modes.
    always_comb begin
        hiloop_s    = op_valid & is_hilo_op(aluop);
        muldiv_s    = is_muldiv_op(aluop);
        signed_op_s = (aluop == OP_MULT) | (aluop == OP_DIV);
        div_op_s    = (aluop == OP_DIV) | (aluop == OP_DIVU);
        mag_a_s     = (signed_op_s & src_a[W-1]) ? (~src_a + {{(W-1){1'b0}}, 1'b1}) : src_a;
        mag_b_s     = (signed_op_s & src_b[W-1]) ? (~src_b + {{(W-1){1'b0}}, 1'b1}) : src_b;
    end

    // Two's-complement sign correction of the raw unsigned result.
    always_comb begin
        prod_fix_s = res_neg_r ? (~raw_res_s + {{(2*W-1){1'b0}}, 1'b1}) : raw_res_s;
        quo_fix_s  = res_neg_r ? (~raw_res_s[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : raw_res_s[W-1:0];
        rem_fix_s  = rem_neg_r ? (~raw_res_s[2*W-1:W] + {{(W-1){1'b0}}, 1'b1}) : raw_res_s[2*W-1:W];
    end

    // FSM next state, datapath control and HI/LO write selection.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        step_s      = 1'b0;
        hi_we_s     = 1'b0;
        lo_we_s     = 1'b0;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (hiloop_s & ~flush) begin
                    if (muldiv_s) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else if (aluop == OP_MTHI) begin
                        hi_we_s  = 1'b1;
                        hi_nxt_s = src_a;
                    end else if (aluop == OP_MTLO) begin
                        lo_we_s  = 1'b1;
                        lo_nxt_s = src_a;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == CW'(ITER - 1)) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_FIX: begin
                state_nxt_s = ST_IDLE;
                if (flush) begin
                    hi_we_s = 1'b0;
                end else begin
                    hi_we_s = 1'b1;
                    lo_we_s = 1'b1;
                    if (!is_div_r) begin
                        hi_nxt_s = prod_fix_s[2*W-1:W];
                        lo_nxt_s = prod_fix_s[W-1:0];
                    end else if (dz_r) begin
                        hi_nxt_s = raw_a_r;
                        lo_nxt_s = {W{1'b1}};
                    end else begin
                        hi_nxt_s = rem_fix_s;
                        lo_nxt_s = quo_fix_s;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Iteration counter: counts RUN steps, zero everywhere else.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CW{1'b0}};
        end else if (step_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    // Capture op kind, result signs and raw dividend when an op is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_div_r  <= 1'b0;
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            dz_r      <= 1'b0;
            raw_a_r   <= {W{1'b0}};
        end else if (accept_s) begin
            is_div_r  <= div_op_s;
            res_neg_r <= signed_op_s & (src_a[W-1] ^ src_b[W-1]);
            rem_neg_r <= signed_op_s & div_op_s & src_a[W-1];
            dz_r      <= div_op_s & (src_b == {W{1'b0}});
            raw_a_r   <= src_a;
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= {W{1'b0}};
            lo_r <= {W{1'b0}};
        end else begin
            if (hi_we_s) begin
                hi_r <= hi_nxt_s;
            end
            if (lo_we_s) begin
                lo_r <= lo_nxt_s;
            end
        end
    end

    muldiv_iter #(
        .W (W)
    ) u_iter (
        .clk    (clk),
        .resetn (resetn),
        .load   (accept_s),
        .step   (step_s),
        .is_div (is_div_r),
        .op_a   (mag_a_s),
        .op_b   (mag_b_s),
        .result (raw_res_s)
    );

    // Pipeline-facing outputs; stall and read data must be visible in the same cycle.
    always_comb begin
        stall = hiloop_s & (state_r != ST_IDLE) & ~flush;
        busy  = (state_r == ST_RUN) | (state_r == ST_FIX);
        hi    = hi_r;
        lo    = lo_r;
        if (op_valid & (aluop == OP_MFHI)) begin
            hilo_rdata = hi_r;
        end else if (op_valid & (aluop == OP_MFLO)) begin
            hilo_rdata = lo_r;
        end else begin
            hilo_rdata = {W{1'b0}};
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl. Inputs change on the
// falling edge; outputs are sampled 1ns later.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [4:0]  aluop;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic [31:0] hilo_rdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_errors;
    int cyc;

    hilo_muldiv_ctrl #(.ITER(32), .W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .op_valid   (op_valid),
        .aluop      (aluop),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stall      (stall),
        .hilo_rdata (hilo_rdata),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        op_valid = 1'b0;
        aluop    = 5'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        flush    = 1'b0;
    endtask

    // Present an op for exactly one cycle; returns at the next falling edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        aluop    = op;
        src_a    = a;
        src_b    = b;
        @(negedge clk);
        clear_inputs();
    endtask

    // Count busy cycles until idle, bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        #1;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        check_eq("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Count stall cycles with the current op held, bounded.
    task automatic count_stall(output int cycles);
        cycles = 0;
        #1;
        while (stall && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        resetn = 1'b0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        check_eq("rst_rdata", hilo_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Signed multiply -3 * 7 = -21; busy c1..c33, idle c34.
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        #1;
        check_eq("mult_busy_c1", {31'd0, busy}, 32'd1);
        op_valid = 1'b1;
        aluop    = 5'b00001;
        #1;
        check_eq("nonhilo_no_stall", {31'd0, stall}, 32'd0);
        clear_inputs();
        wait_idle(cyc);
        check_eq("mult_busy_cycles", cyc, 32'd33);
        check_eq("mult_hi", hi, 32'hFFFFFFFF);
        check_eq("mult_lo", lo, 32'hFFFFFFEB);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(cyc);
        check_eq("multu_hi", hi, 32'hFFFFFFFE);
        check_eq("multu_lo", lo, 32'h00000001);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        check_eq("div_lo", lo, 32'hFFFFFFFD);
        check_eq("div_hi", hi, 32'hFFFFFFFF);

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc);
        check_eq("div_ovf_lo", lo, 32'h80000000);
        check_eq("div_ovf_hi", hi, 32'h00000000);

        issue(OP_DIV, 32'hFFFFFFFB, 32'd0);
        wait_idle(cyc);
        check_eq("div_dz_cycles", cyc, 32'd33);
        check_eq("div_dz_lo", lo, 32'hFFFFFFFF);
        check_eq("div_dz_hi", hi, 32'hFFFFFFFB);

        // divu 100/7 with mflo waiting from c1: stall c1..c33.
        @(negedge clk);
        op_valid = 1'b1; aluop = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        op_valid = 1'b1; aluop = OP_MFLO; src_a = 32'd0; src_b = 32'd0;
        count_stall(cyc);
        check_eq("mflo_stall_cycles", cyc, 32'd33);
        check_eq("mflo_rdata", hilo_rdata, 32'h0000000E);
        check_eq("divu_hi", hi, 32'd2);
        @(negedge clk);
        clear_inputs();

        issue(OP_DIVU, 32'h00001234, 32'd0);
        wait_idle(cyc);
        check_eq("divu_dz_lo", lo, 32'hFFFFFFFF);
        check_eq("divu_dz_hi", hi, 32'h00001234);
        @(negedge clk);
        op_valid = 1'b1; aluop = OP_MTHI; src_a = 32'hA5A5A5A5;
        #1;
        check_eq("mthi_no_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("mthi_hi", hi, 32'hA5A5A5A5);
        check_eq("mthi_lo_kept", lo, 32'hFFFFFFFF);

        // Second muldiv held behind the first; accepted once idle.
        issue(OP_MULT, 32'd2, 32'd3);
        op_valid = 1'b1; aluop = OP_MULTU; src_a = 32'd4; src_b = 32'd5;
        count_stall(cyc);
        check_eq("held_stall_cycles", cyc, 32'd33);
        check_eq("held_first_lo", lo, 32'd6);
        @(negedge clk);
        clear_inputs();
        wait_idle(cyc);
        check_eq("held_busy_cycles", cyc, 32'd33);
        check_eq("held_lo", lo, 32'd20);
        check_eq("held_hi", hi, 32'd0);

        // Flush at c10 of a running mult.
        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h11, 32'd0);
        issue(OP_MULT, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check_eq("flush_c10_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("flush_busy", {31'd0, busy}, 32'd0);
        repeat (30) @(negedge clk);
        #1;
        check_eq("flush_hi", hi, 32'h11);
        check_eq("flush_lo", lo, 32'h11);

        // Flush in the accept cycle blocks both mtlo and a muldiv.
        @(negedge clk);
        op_valid = 1'b1; aluop = OP_MTLO; src_a = 32'h22; flush = 1'b1;
        @(negedge clk);
        aluop = OP_MULT; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("flush_acc_lo", lo, 32'h11);
        check_eq("flush_acc_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-RUN.
        issue(OP_MULTU, 32'd3, 32'd3);
        repeat (4) @(negedge clk);
        op_valid = 1'b1; aluop = OP_MFHI;
        #1;
        check_eq("pre_rst_stall", {31'd0, stall}, 32'd1);
        check_eq("pre_rst_rdata", hilo_rdata, 32'h11);
        resetn = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_stall", {31'd0, stall}, 32'd0);
        check_eq("arst_hi", hi, 32'd0);
        check_eq("arst_lo", lo, 32'd0);
        check_eq("arst_rdata", hilo_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
